// File: rtl/pin_chain_tester.sv
// rtl/pin_chain_tester.sv - pin-chain pattern driver/checker (optional PRBS phase: PIN_CHAIN_TESTER_PRBS_EN)
module pin_chain_tester #(
    parameter int CHAINS        = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter int PRBS_STEPS    = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic [CHAINS-1:0] chain_o,
    output logic              chain_oe_o,
    input  logic [CHAINS-1:0] chain_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [CHAINS-1:0] fail_mask_o,
    output logic [15:0]       err_count_o
);

    generate
        if (SETTLE_CYCLES < 3) begin : g_bad_settle
            $error("pin_chain_tester: SETTLE_CYCLES must be >= 3");
        end
        if (CHAINS < 1 || CHAINS > 16) begin : g_bad_chains
            $error("pin_chain_tester: CHAINS must be 1..16");
        end
        if (PRBS_STEPS < 1) begin : g_bad_prbs
            $error("pin_chain_tester: PRBS_STEPS must be >= 1");
        end
    endgenerate

    localparam int CNT_W = $clog2(SETTLE_CYCLES);

    // NEXT is folded into the SAMPLE cycle as a combinational decision.
    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_SAMPLE, S_DONE} state_t;
    typedef enum logic [2:0] {P_ALL0, P_ALL1, P_WALK1, P_WALK0, P_PRBS} phase_t;

    state_t            r_state;
    phase_t            r_phase;
    logic [15:0]       r_step;
    logic [CNT_W-1:0]  r_cnt;
    logic [CHAINS-1:0] r_chain;
    logic              r_oe;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [CHAINS-1:0] r_mask;
    logic [15:0]       r_err;
    logic [CHAINS-1:0] r_sync1;
    logic [CHAINS-1:0] r_sync2;
`ifdef PIN_CHAIN_TESTER_PRBS_EN
    logic [15:0]       r_lfsr;
    logic              w_lfsr_fb;
    logic              w_last_prbs;
`endif

    logic [CHAINS-1:0] w_walk;
    logic [CHAINS-1:0] w_pattern;
    logic [CHAINS-1:0] w_mism;
    logic [CHAINS-1:0] w_mask_next;
    logic [4:0]        w_pop;
    logic [16:0]       w_sum;
    logic [15:0]       w_err_next;
    logic              w_last_walk;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= chain_i;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_walk = CHAINS'(1) << r_step;
        case (r_phase)
            P_ALL0:  w_pattern = '0;
            P_ALL1:  w_pattern = '1;
            P_WALK1: w_pattern = w_walk;
            P_WALK0: w_pattern = ~w_walk;
`ifdef PIN_CHAIN_TESTER_PRBS_EN
            P_PRBS:  w_pattern = r_lfsr[CHAINS-1:0];
`endif
            default: w_pattern = '0;
        endcase
    end

    // r_chain holds the expected value for the whole step, so it is the compare reference.
    always_comb begin
        w_mism = r_sync2 ^ r_chain;
        w_pop  = '0;
        for (int i = 0; i < CHAINS; i++) begin
            w_pop = w_pop + 5'(w_mism[i]);
        end
        w_sum       = {1'b0, r_err} + 17'(w_pop);
        w_err_next  = w_sum[16] ? 16'hFFFF : w_sum[15:0];
        w_mask_next = r_mask | w_mism;
        w_last_walk = (r_step == 16'(CHAINS - 1));
    end

`ifdef PIN_CHAIN_TESTER_PRBS_EN
    assign w_lfsr_fb   = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_last_prbs = (r_step == 16'(PRBS_STEPS - 1));
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_phase <= P_ALL0;
            r_step  <= '0;
            r_cnt   <= '0;
            r_chain <= '0;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_mask  <= '0;
            r_err   <= '0;
`ifdef PIN_CHAIN_TESTER_PRBS_EN
            r_lfsr  <= 16'hACE1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_oe   <= 1'b0;
                    r_done <= 1'b0;
                    if (start_i) begin
                        r_state <= S_DRIVE;
                        r_phase <= P_ALL0;
                        r_step  <= '0;
                        r_mask  <= '0;
                        r_err   <= '0;
                        r_pass  <= 1'b0;
                        r_busy  <= 1'b1;
`ifdef PIN_CHAIN_TESTER_PRBS_EN
                        r_lfsr  <= 16'hACE1;
`endif
                    end
                end
                S_DRIVE: begin
                    r_chain <= w_pattern;
                    r_oe    <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_cnt == CNT_W'(SETTLE_CYCLES - 2)) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    r_mask  <= w_mask_next;
                    r_err   <= w_err_next;
                    r_state <= S_DRIVE;
                    case (r_phase)
                        P_ALL0: r_phase <= P_ALL1;
                        P_ALL1: begin
                            r_phase <= P_WALK1;
                            r_step  <= '0;
                        end
                        P_WALK1: begin
                            if (w_last_walk) begin
                                r_phase <= P_WALK0;
                                r_step  <= '0;
                            end else begin
                                r_step <= r_step + 16'd1;
                            end
                        end
                        P_WALK0: begin
                            if (w_last_walk) begin
`ifdef PIN_CHAIN_TESTER_PRBS_EN
                                r_phase <= P_PRBS;
                                r_step  <= '0;
`else
                                r_state <= S_DONE;
`endif
                            end else begin
                                r_step <= r_step + 16'd1;
                            end
                        end
`ifdef PIN_CHAIN_TESTER_PRBS_EN
                        P_PRBS: begin
                            r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
                            if (w_last_prbs) begin
                                r_state <= S_DONE;
                            end else begin
                                r_step <= r_step + 16'd1;
                            end
                        end
`endif
                        default: r_state <= S_DONE;
                    endcase
                    // Completion outputs are registered here so they appear during the DONE cycle.
                    if ((r_phase == P_WALK0 && w_last_walk
`ifndef PIN_CHAIN_TESTER_PRBS_EN
                        )
`else
                        && 1'b0) || (r_phase == P_PRBS && w_last_prbs)
`endif
                        ) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_pass  <= (w_mask_next == '0);
                        r_oe    <= 1'b0;
                        r_chain <= '0;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign chain_o     = r_chain;
    assign chain_oe_o  = r_oe;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign pass_o      = r_pass;
    assign fail_mask_o = r_mask;
    assign err_count_o = r_err;

endmodule
